// File: rtl/jtcop_layer_mix.sv
// jtcop_layer_mix
// Pixel merger for 2..4 tile/object layers. Each layer is realigned through a
// programmable-length delay line, optionally masked for debug, and the topmost
// opaque pixel is chosen according to a programmable priority order. Per-frame
// win flags (and optional counters) are reported on a registered status bus.
// Build option: define JTCOP_MIX_STATS_EN to add per-layer 16-bit win counters
// on status addresses 0..7; otherwise those addresses read 8'hFF.
module jtcop_layer_mix #(
    parameter int unsigned LAYERS = 4,
    parameter int unsigned PW     = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pxl_cen,
    input  logic                 LHBL,
    input  logic                 LVBL,
    input  logic [LAYERS*PW-1:0] pxl_in,
    input  logic [LAYERS-1:0]    gfx_en,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_addr,
    input  logic [7:0]           cfg_din,
    output logic [PW-1:0]        pxl_out,
    output logic [1:0]           lyr_out,
    output logic                 LHBL_dly,
    output logic                 LVBL_dly,
    input  logic [3:0]           st_addr,
    output logic [7:0]           st_dout
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [3:0]    dly [LAYERS];
    logic [7:0]    prio;
    logic [3:0]    dly_wr;
    logic [PW-1:0] mem [LAYERS][DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [PW-1:0] aln [LAYERS];
    logic          hb1, vb1;
    logic [PW-1:0] aln4 [4];
    logic [3:0]    opq;
    logic [1:0]    sel_lyr;
    logic          sel_opq;
    logic          win, frame_end;
    logic [3:0]    hits, hit_snap;
    logic [7:0]    stat_byte;

    // Delays longer than the buffer saturate at the deepest tap
    assign dly_wr = (cfg_din >= 8'(DEPTH)) ? 4'(DEPTH - 1) : cfg_din[3:0];

    // Configuration registers; a write lands on the clock edge, so a strobe in
    // the same cycle still sees the previous value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAYERS; i++) dly[i] <= 4'd0;
            prio <= 8'hE4;
        end else if (cfg_we) begin
            if (cfg_addr == 3'd4) prio <= cfg_din;
            for (int i = 0; i < LAYERS; i++) begin
                if (cfg_addr == 3'(i)) dly[i] <= dly_wr;
            end
        end
    end

    // Circular delay buffers sharing one write pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            for (int i = 0; i < LAYERS; i++) begin
                for (int j = 0; j < DEPTH; j++) mem[i][j] <= '0;
            end
        end else if (pxl_cen) begin
            wr_ptr <= wr_ptr + 1'b1;
            for (int i = 0; i < LAYERS; i++) mem[i][wr_ptr] <= pxl_in[i*PW +: PW];
        end
    end

    // Stage 1: tap each buffer; zero delay bypasses the buffer with live input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAYERS; i++) aln[i] <= '0;
            hb1 <= 1'b0;
            vb1 <= 1'b0;
        end else if (pxl_cen) begin
            hb1 <= LHBL;
            vb1 <= LVBL;
            for (int i = 0; i < LAYERS; i++) begin
                aln[i] <= (dly[i] == 4'd0) ? pxl_in[i*PW +: PW]
                                           : mem[i][wr_ptr - AW'(dly[i])];
            end
        end
    end

    // Priority scan: follow valid levels until one is opaque; if none is, the
    // last valid level (lowest priority) supplies the backdrop pixel
    always_comb begin
        opq = 4'd0;
        for (int i = 0; i < 4; i++) aln4[i] = '0;
        for (int i = 0; i < LAYERS; i++) begin
            aln4[i] = aln[i];
            opq[i]  = gfx_en[i] && (aln[i][3:0] != 4'd0);
        end
        sel_lyr = 2'd0;
        sel_opq = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if ((32'(prio[2*k +: 2]) < LAYERS) && !sel_opq) begin
                sel_lyr = prio[2*k +: 2];
                sel_opq = opq[prio[2*k +: 2]];
            end
        end
    end

    // Falling LVBL is seen when the blanked pixel reaches selection, so that
    // pixel is never visible and cannot register a win
    assign win       = pxl_cen && sel_opq && hb1 && vb1;
    assign frame_end = pxl_cen && LVBL_dly && !vb1;

    // Stage 2: registered merged pixel and matching blanking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pxl_out  <= '0;
            lyr_out  <= 2'd0;
            LHBL_dly <= 1'b0;
            LVBL_dly <= 1'b0;
        end else if (pxl_cen) begin
            pxl_out  <= aln4[sel_lyr];
            lyr_out  <= sel_lyr;
            LHBL_dly <= hb1;
            LVBL_dly <= vb1;
        end
    end

    // Sticky win flags, snapshotted and cleared once per frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hits     <= 4'd0;
            hit_snap <= 4'd0;
        end else if (frame_end) begin
            hit_snap <= hits;
            hits     <= 4'd0;
        end else if (win) begin
            hits[sel_lyr] <= 1'b1;
        end
    end

`ifdef JTCOP_MIX_STATS_EN
    logic [15:0] cnt      [4];
    logic [15:0] cnt_snap [4];

    // Saturating per-layer win counters, snapshotted with the flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i]      <= 16'd0;
                cnt_snap[i] <= 16'd0;
            end
        end else if (frame_end) begin
            for (int i = 0; i < 4; i++) begin
                cnt_snap[i] <= cnt[i];
                cnt[i]      <= 16'd0;
            end
        end else if (win && (cnt[sel_lyr] != 16'hFFFF)) begin
            cnt[sel_lyr] <= cnt[sel_lyr] + 16'd1;
        end
    end

    // Address {layer, byte} selects one byte of a counter snapshot
    always_comb begin
        stat_byte = st_addr[0] ? cnt_snap[st_addr[2:1]][15:8] : cnt_snap[st_addr[2:1]][7:0];
    end
`else
    assign stat_byte = 8'hFF;
`endif

    // Registered status readback, independent of the pixel enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_dout <= 8'hFF;
        end else begin
            case (st_addr)
                4'd8:    st_dout <= prio;
                4'd9:    st_dout <= {4'b0000, hit_snap};
                default: st_dout <= st_addr[3] ? 8'hFF : stat_byte;
            endcase
        end
    end

endmodule

// File: tb/tb_jtcop_layer_mix.sv
// tb_jtcop_layer_mix: vector table and scoreboard checks for jtcop_layer_mix,
// plus a second instance built with three layers.
`timescale 1ns/1ps
module tb_jtcop_layer_mix;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, pxl_cen, LHBL, LVBL, cfg_we;
    logic [31:0] pxl_in;
    logic [3:0]  gfx_en, st_addr;
    logic [2:0]  cfg_addr;
    logic [7:0]  cfg_din, pxl_out, st_dout;
    logic [1:0]  lyr_out;
    logic        LHBL_dly, LVBL_dly;

    logic [23:0] pxl_in3;
    logic [2:0]  gfx_en3;
    logic [7:0]  pxl_out3, st_dout3;
    logic [1:0]  lyr_out3;
    logic        hbl3, vbl3;

`ifdef JTCOP_MIX_STATS_EN
    localparam int N_WIN = 70000;
`else
    localparam int N_WIN = 10;
`endif

    jtcop_layer_mix #(.LAYERS(4), .PW(8), .DEPTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .pxl_in(pxl_in), .gfx_en(gfx_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_din(cfg_din), .pxl_out(pxl_out), .lyr_out(lyr_out),
        .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly), .st_addr(st_addr), .st_dout(st_dout)
    );

    jtcop_layer_mix #(.LAYERS(3), .PW(8), .DEPTH(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .pxl_in(pxl_in3), .gfx_en(gfx_en3), .cfg_we(1'b0), .cfg_addr(3'd0),
        .cfg_din(8'd0), .pxl_out(pxl_out3), .lyr_out(lyr_out3),
        .LHBL_dly(hbl3), .LVBL_dly(vbl3), .st_addr(4'd9), .st_dout(st_dout3)
    );

    typedef struct {
        int         due;
        logic [7:0] pix;
        logic [1:0] lyr;
        logic       chk_bl;
        logic       hb;
        logic       vb;
    } exp_t;

    typedef struct {
        logic [31:0] pin;
        logic [3:0]  en;
        logic [7:0]  pr;
        logic        hb;
        logic        vb;
        logic [7:0]  pix;
        logic [1:0]  lyr;
    } vec_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   scnt  = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // One pixel strobe; afterwards compare every scoreboard entry now due
    task automatic strobe();
        exp_t e;
        pxl_cen = 1'b1;
        @(posedge clk);
        #1;
        pxl_cen = 1'b0;
        scnt++;
        while (sbq.size() > 0 && sbq[0].due <= scnt) begin
            e = sbq.pop_front();
            check("sb_due", 32'(scnt), 32'(e.due));
            check("sb_pix", 32'(pxl_out), 32'(e.pix));
            check("sb_lyr", 32'(lyr_out), 32'(e.lyr));
            if (e.chk_bl) begin
                check("sb_hbl", 32'(LHBL_dly), 32'(e.hb));
                check("sb_vbl", 32'(LVBL_dly), 32'(e.vb));
            end
        end
    endtask

    // Expected output for the pixel driven on the next strobe, lat strobes on
    task automatic push(input int lat, input logic [7:0] pix, input logic [1:0] lyr,
                        input logic chk_bl, input logic hb, input logic vb);
        exp_t e;
        e.due = scnt + lat;
        e.pix = pix;
        e.lyr = lyr;
        e.chk_bl = chk_bl;
        e.hb = hb;
        e.vb = vb;
        sbq.push_back(e);
    endtask

    task automatic cfg(input logic [2:0] a, input logic [7:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_din = d;
        idle();
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 20 && sbq.size() > 0; t++) strobe();
        check("sb_drain", 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    task automatic st_read(input string nm, input logic [3:0] a, input logic [7:0] exp);
        st_addr = a;
        idle();
        check(nm, 32'(st_dout), 32'(exp));
    endtask

    function automatic logic [7:0] rv(input int k);
        rv = {4'(k), 4'(k % 15 + 1)};
    endfunction

    initial begin
        vec_t       vt [11];
        logic [7:0] cur_prio;

        // {L3,L2,L1,L0} pixels, enables, priority, blanking, expected pixel/layer
        vt[0]  = '{pin: 32'h45352515, en: 4'hF, pr: 8'hE4, hb: 1'b1, vb: 1'b1, pix: 8'h15, lyr: 2'd0};
        vt[1]  = '{pin: 32'h37352515, en: 4'hF, pr: 8'h1B, hb: 1'b1, vb: 1'b1, pix: 8'h37, lyr: 2'd3};
        vt[2]  = '{pin: 32'h37352515, en: 4'h7, pr: 8'h1B, hb: 1'b1, vb: 1'b1, pix: 8'h35, lyr: 2'd2};
        vt[3]  = '{pin: 32'h40302A10, en: 4'hF, pr: 8'hE4, hb: 1'b0, vb: 1'b1, pix: 8'h2A, lyr: 2'd1};
        vt[4]  = '{pin: 32'h40302010, en: 4'hF, pr: 8'hE4, hb: 1'b0, vb: 1'b0, pix: 8'h40, lyr: 2'd3};
        vt[5]  = '{pin: 32'h4C3C2C1C, en: 4'h0, pr: 8'hE4, hb: 1'b1, vb: 1'b1, pix: 8'h4C, lyr: 2'd3};
        vt[6]  = '{pin: 32'h47302211, en: 4'hF, pr: 8'h4E, hb: 1'b1, vb: 1'b1, pix: 8'h47, lyr: 2'd3};
        vt[7]  = '{pin: 32'h40302211, en: 4'hF, pr: 8'h4E, hb: 1'b1, vb: 1'b1, pix: 8'h11, lyr: 2'd0};
        vt[8]  = '{pin: 32'h40302010, en: 4'hF, pr: 8'h4E, hb: 1'b1, vb: 1'b1, pix: 8'h20, lyr: 2'd1};
        vt[9]  = '{pin: 32'h4D3D2D10, en: 4'hF, pr: 8'h00, hb: 1'b1, vb: 1'b1, pix: 8'h10, lyr: 2'd0};
        vt[10] = '{pin: 32'h45352515, en: 4'hC, pr: 8'hE4, hb: 1'b1, vb: 1'b1, pix: 8'h35, lyr: 2'd2};

        // Reset with live opaque data and strobes: outputs must stay cleared
        rst_n = 1'b0; pxl_cen = 1'b1; LHBL = 1'b1; LVBL = 1'b1;
        pxl_in = 32'h45352515; gfx_en = 4'hF; cfg_we = 1'b0; cfg_addr = 3'd0;
        cfg_din = 8'd0; st_addr = 4'd8; pxl_in3 = 24'h302010; gfx_en3 = 3'b111;
        repeat (3) idle();
        check("rst_pxl", 32'(pxl_out), 32'h0);
        check("rst_lyr", 32'(lyr_out), 32'h0);
        check("rst_hbl", 32'(LHBL_dly), 32'h0);
        check("rst_vbl", 32'(LVBL_dly), 32'h0);
        check("rst_st", 32'(st_dout), 32'hFF);
        check("rst_st3", 32'(st_dout3), 32'hFF);
        check("rst_pxl3", 32'(pxl_out3), 32'h0);
        rst_n = 1'b1;
        pxl_cen = 1'b0;
        idle();
        check("prio_reset", 32'(st_dout), 32'hE4);
        check("snap3_reset", 32'(st_dout3), 32'h00);

        // Selection table, delays all zero
        cur_prio = 8'hE4;
        for (int n = 0; n < 11; n++) begin
            if (vt[n].pr != cur_prio) begin
                cfg(3'd4, vt[n].pr);
                cur_prio = vt[n].pr;
            end
            pxl_in = vt[n].pin;
            gfx_en = vt[n].en;
            LHBL = vt[n].hb;
            LVBL = vt[n].vb;
            push(2, vt[n].pix, vt[n].lyr, 1'b1, vt[n].hb, vt[n].vb);
            strobe();
            strobe();
        end

        // Three-layer build: all transparent picks the lowest valid level (layer 2)
        check("l3_bg_pix", 32'(pxl_out3), 32'h30);
        check("l3_bg_lyr", 32'(lyr_out3), 32'd2);
        check("l3_hbl", 32'(hbl3), 32'd1);
        check("l3_vbl", 32'(vbl3), 32'd1);
        pxl_in3 = 24'h302B10;
        strobe();
        strobe();
        check("l3_opq_pix", 32'(pxl_out3), 32'h2B);
        check("l3_opq_lyr", 32'(lyr_out3), 32'd1);

        // Status map and ignored config addresses
        st_read("st_prio", 4'd8, 8'hE4);
        cfg(3'd5, 8'h00);
        cfg(3'd7, 8'h1B);
        st_read("prio_ignored", 4'd8, 8'hE4);
        st_read("st_a10", 4'd10, 8'hFF);
        st_read("st_a15", 4'd15, 8'hFF);

        // Layer-1 ramp behind delay 3 (total lag 5), then delay 20 clamped to 7 (lag 9)
        LHBL = 1'b1; LVBL = 1'b1; gfx_en = 4'hF;
        cfg(3'd1, 8'd3);
        for (int k = 0; k < 16; k++) begin
            pxl_in = {16'h0000, rv(k), 8'h00};
            push(5, rv(k), 2'd1, 1'b0, 1'b1, 1'b1);
            strobe();
        end
        pxl_in = 32'h0;
        drain();
        cfg(3'd1, 8'd20);
        for (int k = 16; k < 32; k++) begin
            pxl_in = {16'h0000, rv(k), 8'h00};
            push(9, rv(k), 2'd1, 1'b0, 1'b1, 1'b1);
            strobe();
        end
        pxl_in = 32'h0;
        drain();

        // Delay write on the same cycle as a strobe: old delay used on that strobe
        pxl_in = 32'h00000081; strobe();
        pxl_in = 32'h00000082; strobe();
        pxl_in = 32'h00000083;
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_din = 8'd2;
        strobe();
        cfg_we = 1'b0;
        pxl_in = 32'h00000084; strobe();
        check("cfg_same_strobe", 32'(pxl_out), 32'h83);
        check("cfg_same_lyr", 32'(lyr_out), 32'd0);
        pxl_in = 32'h00000085; strobe();
        check("cfg_next_strobe", 32'(pxl_out), 32'h82);
        pxl_in = 32'h00000086; strobe();
        check("cfg_after", 32'(pxl_out), 32'h83);
        cfg(3'd0, 8'd0);

        // Frame statistics: layer 0 wins 3, layer 2 wins N_WIN, blanked layer-1 pixels
        rst_n = 1'b0; idle(); rst_n = 1'b1;
        sbq.delete();
        st_read("snap_clear", 4'd9, 8'h00);
        LHBL = 1'b1; LVBL = 1'b1; gfx_en = 4'hF;
        pxl_in = 32'h40302015; repeat (3) strobe();
        pxl_in = 32'h40332010; repeat (N_WIN) strobe();
        LHBL = 1'b0; pxl_in = 32'h40302B10; repeat (4) strobe();
        // Opaque layer-1 pixel on the LVBL fall must not be counted
        LHBL = 1'b1; LVBL = 1'b0; strobe();
        pxl_in = 32'h40302010; repeat (3) strobe();
        st_read("hit_snap", 4'd9, 8'h05);
`ifdef JTCOP_MIX_STATS_EN
        st_read("cnt0_lo", 4'd0, 8'h03);
        st_read("cnt0_hi", 4'd1, 8'h00);
        st_read("cnt1_lo", 4'd2, 8'h00);
        st_read("cnt1_hi", 4'd3, 8'h00);
        st_read("cnt2_lo", 4'd4, 8'hFF);
        st_read("cnt2_hi", 4'd5, 8'hFF);
        st_read("cnt3_lo", 4'd6, 8'h00);
`else
        st_read("nostat_a0", 4'd0, 8'hFF);
        st_read("nostat_a4", 4'd4, 8'hFF);
`endif

        // Second frame without visible wins: flags were cleared by the last fall
        LVBL = 1'b1; repeat (4) strobe();
        LVBL = 1'b0; repeat (3) strobe();
        st_read("hit_cleared", 4'd9, 8'h00);
`ifdef JTCOP_MIX_STATS_EN
        st_read("cnt2_cleared", 4'd4, 8'h00);
        st_read("cnt0_cleared", 4'd0, 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtcop_layer_mix.md
# jtcop_layer_mix

Parametrised pixel merger for up to four tile/object layers, sitting between the layer generators (BAC06 tile layers, object engine) and palette lookup in the video top level. It realigns each layer with a programmable per-layer pixel delay, masks layers for debug, selects the topmost opaque pixel according to a programmable priority order, and reports per-frame layer statistics on the status bus. It generalises the fixed three-tile-plus-object wiring into a configurable-depth, configurable-count mixer.

## Interface
Parameters:
- LAYERS, 4, number of input layers, legal range 2..4.
- PW, 8, pixel width per layer; bits [3:0] are the colour index, 0 = transparent.
- DEPTH, 8, delay-line length per layer in pixels, power of two, 2..16.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  synchronous active-low reset.
- pxl_cen  in  1  pixel clock enable.
- LHBL, LVBL  in  1 each  active-low blanking, aligned with pxl_in.
- pxl_in  in  LAYERS*PW  layer pixels; layer i in bits [i*PW +: PW].
- gfx_en  in  LAYERS  debug enable per layer; 0 forces the layer transparent.
- cfg_we  in  1  configuration write strobe.
- cfg_addr  in  3  register select: 0..3 = delay of layer 0..3, 4 = priority order.
- cfg_din  in  8  write data.
- pxl_out  out  PW  merged pixel.
- lyr_out  out  2  index of the layer that produced pxl_out.
- LHBL_dly, LVBL_dly  out  1 each  blanking delayed to match pxl_out.
- st_addr  in  4  status select.
- st_dout  out  8  status read data, registered.

## Operation
- Delay registers dly[i] (4 bits): reset 0. Written values ≥ DEPTH clamp to DEPTH-1. Writes to layers ≥ LAYERS, and to cfg_addr 5..7, are ignored.
- Priority register prio (8 bits): reset 8'hE4. Field prio[2k+1:2k] is the layer at level k; level 0 is the top. Fields naming a layer ≥ LAYERS are skipped.
- Delay line: one DEPTH-entry circular buffer per layer, sharing a write pointer.
  - On each pxl_cen, pxl_in is written at the pointer and the pointer increments, wrapping at DEPTH.
  - Aligned pixel a[i] is the input captured dly[i] strobes before the current one. dly = 0 selects the input captured at the current strobe.
  - Reset clears every buffer entry to 0 (transparent) and the pointer to 0.
- Masking: a[i] is treated as transparent when gfx_en[i] = 0 or a[i][3:0] = 0.
- Selection: scan levels 0 to 3 and take the first non-skipped level whose layer is opaque.
  - If no layer is opaque, output the unmasked a[] of the lowest-priority valid level. Its colour 0 is the backdrop.
  - lyr_out carries the index of the chosen layer.
- Hit flags (4 bits, sticky): bit i is set when layer i wins an opaque pixel with LHBL & LVBL high.
  - At the LVBL falling edge, detected on pxl_cen, the working flags are copied to hit_snap and then cleared.
  - If a set and the falling-edge copy/clear fall on the same strobe, the copy/clear wins. The pixel on that strobe is blanked and cannot set a flag.
- Status map: 8 → prio; 9 → {4'b0, hit_snap}; 0..7 → statistics (see Configuration); 10..15 → 8'hFF.
- Reset values: pxl_out 0, lyr_out 0, LHBL_dly 0, LVBL_dly 0, st_dout 8'hFF, hit flags and hit_snap 0.

## Timing
- Pipeline stages: stage 1 writes the buffer and reads the aligned pixels; stage 2 registers the selection. Latency is 2 pxl_cen strobes plus dly[i] for layer i. LHBL_dly and LVBL_dly are delayed by exactly 2 strobes.
- A cfg write takes effect on the next pxl_cen after the write cycle. On a cycle with both cfg_we and pxl_cen, that strobe uses the old value.
- A delay change mid-line does not flush the buffer. Old data is re-tapped.
- st_dout updates one clk after st_addr changes, independent of pxl_cen.
- If rst_n goes low mid-frame, all state is cleared on that edge. Outputs show transparent backdrop colour 0 until new data has propagated through the pipeline.

## Configuration
- JTCOP_MIX_STATS_EN, when defined, adds per-layer 16-bit opaque-pixel counters.
  - A counter increments when its layer wins an opaque pixel with LHBL & LVBL high. It saturates at 16'hFFFF.
  - The counters are snapshot and cleared on the same edge as the hit flags.
  - Status address {layer[1:0], byte} returns the snapshot: byte 0 = low byte, byte 1 = high byte. Layers ≥ LAYERS read 0.
- When undefined, no counters are built and addresses 0..7 read 8'hFF.

## Test plan
- Reset, then one strobe with all layers opaque (colour 5) and prio 8'hE4 → after 2 strobes, pxl_out = layer-0 pixel, lyr_out = 0; all outputs 0 during reset.
- Write prio = 8'h1B, layer 3 = 8'h37, others opaque → lyr_out = 3, pxl_out = 8'h37. Then set gfx_en[3] = 0 → lyr_out = 2.
- Write dly[1] = 3 and feed a ramp on layer 1 with the other layers transparent → pxl_out lags the ramp by 5 strobes. Write dly[1] = 20 → clamped delay 7, total lag 9.
- All layers colour 0, prio 8'hE4, LAYERS = 3 → pxl_out = layer-2 value, lyr_out = 2.
- One frame where layer 2 wins 70000 visible pixels and layer 0 wins 3, with the macro defined → after the LVBL fall, st_addr 4/5 read FF/FF, st_addr 0/1 read 03/00, st_addr 9 reads 8'h05. Without the macro, st_addr 0 reads FF.
- cfg_we for dly[0] coincident with pxl_cen → the change appears one strobe later. An LVBL falling edge coincident with a win → the win is not counted and the flags are cleared.
